// File: rtl/VX_tcu_pkg.sv
// Shared TCU definitions: format IDs, DRL step record and per-format step width.
// Used by tcu_drl_mask_seq (optional TCU_DRL_MASK_SEQ_PERF_EN counters live in the top).
package VX_tcu_pkg;

    localparam int         TCU_MAX_INPUTS = 8;
    localparam logic [2:0] TCU_FP32_ID    = 3'd0;
    localparam logic [2:0] TCU_FP16_ID    = 3'd1;
    localparam logic [2:0] TCU_BF16_ID    = 3'd2;
    localparam int         TCU_DRL_SW     = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tcu_drl_state_e;

    typedef struct packed {
        logic [TCU_MAX_INPUTS-1:0] vld_mask;
        logic [2:0]                fmt;
        logic [TCU_DRL_SW-1:0]     step;
        logic                      first;
        logic                      last;
    } tcu_drl_step_t;

    // Elements consumed per step; 0 marks a format the datapath cannot process.
    function automatic int tcu_drl_eps(input logic [2:0] fmt, input int max_inputs);
        case (fmt)
            TCU_FP32_ID:              return max_inputs / 2;
            TCU_FP16_ID, TCU_BF16_ID: return max_inputs;
            default:                  return 0;
        endcase
    endfunction

endpackage

// File: rtl/tcu_drl_mask_therm.sv
// Combinational thermometer mask: n ones for FP16/BF16, 2n ones for FP32, zero otherwise.
// Sub-block of tcu_drl_mask_seq (TCU_DRL_MASK_SEQ_PERF_EN has no effect here).
module tcu_drl_mask_therm
    import VX_tcu_pkg::*;
#(
    parameter int MAX_INPUTS = TCU_MAX_INPUTS,
    parameter int NW         = $clog2(TCU_MAX_INPUTS) + 1
) (
    input  logic [NW-1:0]         n,
    input  logic [2:0]            fmt,
    output logic [MAX_INPUTS-1:0] mask
);

    logic [NW:0] lim_s;

    // Number of mask bits to set, then the thermometer itself
    always_comb begin
        case (fmt)
            TCU_FP32_ID:              lim_s = {n, 1'b0};
            TCU_FP16_ID, TCU_BF16_ID: lim_s = {1'b0, n};
            default:                  lim_s = '0;
        endcase
        mask = '0;
        for (int i = 0; i < MAX_INPUTS; i++) begin
            mask[i] = ((NW+1)'(i) < lim_s);
        end
    end

endmodule

// File: rtl/tcu_drl_mask_seq.sv
// Splits one dot-product request into datapath-width steps and emits a valid mask per step.
// Define TCU_DRL_MASK_SEQ_PERF_EN to add perf_steps/perf_stalls counters.
module tcu_drl_mask_seq
    import VX_tcu_pkg::*;
#(
    parameter int MAX_INPUTS = TCU_MAX_INPUTS,
    parameter int KW         = 16,
    parameter int SW         = KW
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_fmt,
    input  logic [KW-1:0]         req_count,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MAX_INPUTS-1:0] out_vld_mask,
    output logic [2:0]            out_fmt,
    output logic [SW-1:0]         out_step,
    output logic                  out_first,
    output logic                  out_last
`ifdef TCU_DRL_MASK_SEQ_PERF_EN
    ,
    output logic [31:0]           perf_steps,
    output logic [31:0]           perf_stalls
`endif
);

    localparam int NW = $clog2(MAX_INPUTS) + 1;

    typedef struct packed {
        logic [MAX_INPUTS-1:0] vld_mask;
        logic [2:0]            fmt;
        logic [SW-1:0]         step;
        logic                  first;
        logic                  last;
    } step_t;

    tcu_drl_state_e        state_q, state_d;
    logic [KW-1:0]         rem_q, rem_d;
    step_t                 out_q, out_d;
    logic                  out_valid_q, out_valid_d;

    logic [2:0]            ld_fmt_s;
    logic [KW-1:0]         ld_rem_s;
    logic [KW-1:0]         ld_eps_s;
    logic [KW-1:0]         cur_eps_s;
    logic [NW-1:0]         ld_n_s;
    logic [MAX_INPUTS-1:0] ld_mask_s;
    logic                  ld_last_s;
    logic                  out_hs_s;

    assign req_ready = (state_q == ST_IDLE);
    assign out_hs_s  = out_valid_q && out_ready;

    // Remaining count and format of the step that would be loaded next
    always_comb begin
        cur_eps_s = KW'(tcu_drl_eps(out_q.fmt, MAX_INPUTS));
        if (state_q == ST_IDLE) begin
            ld_fmt_s = req_fmt;
            ld_rem_s = req_count;
        end else begin
            ld_fmt_s = out_q.fmt;
            ld_rem_s = rem_q - cur_eps_s;
        end
        ld_eps_s  = KW'(tcu_drl_eps(ld_fmt_s, MAX_INPUTS));
        ld_last_s = (ld_eps_s == '0) || (ld_rem_s <= ld_eps_s);
        if (ld_rem_s < ld_eps_s) begin
            ld_n_s = NW'(ld_rem_s);
        end else begin
            ld_n_s = NW'(ld_eps_s);
        end
    end

    tcu_drl_mask_therm #(
        .MAX_INPUTS (MAX_INPUTS),
        .NW         (NW)
    ) u_therm (
        .n    (ld_n_s),
        .fmt  (ld_fmt_s),
        .mask (ld_mask_s)
    );

    // Next-state and next-output decode
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d     = ST_RUN;
                    rem_d       = ld_rem_s;
                    out_valid_d = 1'b1;
                    out_d       = '{vld_mask: ld_mask_s, fmt: ld_fmt_s, step: '0,
                                    first: 1'b1, last: ld_last_s};
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            ST_RUN: begin
                // The last step never computes a successor, so rem cannot underflow
                if (out_hs_s && out_q.last) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end else if (out_hs_s) begin
                    rem_d          = ld_rem_s;
                    out_d.vld_mask = ld_mask_s;
                    out_d.step     = out_q.step + {{(SW-1){1'b0}}, 1'b1};
                    out_d.first    = 1'b0;
                    out_d.last     = ld_last_s;
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State, counters and output register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_vld_mask = out_q.vld_mask;
    assign out_fmt      = out_q.fmt;
    assign out_step     = out_q.step;
    assign out_first    = out_q.first;
    assign out_last     = out_q.last;

`ifdef TCU_DRL_MASK_SEQ_PERF_EN
    logic [31:0] perf_steps_q, perf_steps_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;

    // Handshake and stall counters, wrapping naturally at 2^32
    always_comb begin
        perf_steps_d  = perf_steps_q + (out_hs_s ? 32'd1 : 32'd0);
        perf_stalls_d = perf_stalls_q + ((out_valid_q && !out_ready) ? 32'd1 : 32'd0);
    end

    // Performance counter registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_steps_q  <= 32'd0;
            perf_stalls_q <= 32'd0;
        end else begin
            perf_steps_q  <= perf_steps_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_steps  = perf_steps_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_tcu_drl_mask_seq.sv
// Scoreboard bench for tcu_drl_mask_seq with MAX_INPUTS=8.
// Also checks perf counters when TCU_DRL_MASK_SEQ_PERF_EN is defined.
module tb_tcu_drl_mask_seq;
    import VX_tcu_pkg::*;

    localparam int MI = 8;
    localparam int KW = 16;
    localparam int SW = 16;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_fmt   = 3'd0;
    logic [KW-1:0] req_count = 16'd0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [MI-1:0] out_vld_mask;
    logic [2:0]    out_fmt;
    logic [SW-1:0] out_step;
    logic          out_first;
    logic          out_last;
`ifdef TCU_DRL_MASK_SEQ_PERF_EN
    logic [31:0]   perf_steps;
    logic [31:0]   perf_stalls;
`endif

    tcu_drl_mask_seq #(.MAX_INPUTS(MI), .KW(KW), .SW(SW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_fmt      (req_fmt),
        .req_count    (req_count),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_vld_mask (out_vld_mask),
        .out_fmt      (out_fmt),
        .out_step     (out_step),
        .out_first    (out_first),
        .out_last     (out_last)
`ifdef TCU_DRL_MASK_SEQ_PERF_EN
        ,
        .perf_steps   (perf_steps),
        .perf_stalls  (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [MI-1:0] mask;
        logic [2:0]    fmt;
        logic [SW-1:0] step;
        logic          first;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   last_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   hs_cnt = 0;
    int   stall_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: expand one request into its expected steps
    task automatic push_req(input logic [2:0] fmt, input int k);
        int eps;
        int rem;
        int s;
        int n;
        int nbits;
        logic [MI-1:0] m;
        exp_t e;
        if (fmt == TCU_FP32_ID) eps = MI / 2;
        else if (fmt == TCU_FP16_ID || fmt == TCU_BF16_ID) eps = MI;
        else eps = 0;
        if (eps == 0 || k == 0) begin
            e = '{mask: '0, fmt: fmt, step: '0, first: 1'b1, last: 1'b1};
            exp_q.push_back(e);
        end else begin
            rem = k;
            s = 0;
            while (rem > 0) begin
                n = (rem < eps) ? rem : eps;
                nbits = (fmt == TCU_FP32_ID) ? 2 * n : n;
                m = '0;
                for (int b = 0; b < nbits; b++) m[b] = 1'b1;
                e = '{mask: m, fmt: fmt, step: SW'(s), first: (s == 0), last: (rem <= eps)};
                exp_q.push_back(e);
                rem -= eps;
                s++;
            end
        end
    endtask

    task automatic do_req(input string tag, input logic [2:0] fmt, input int k);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_fmt   = fmt;
        req_count = KW'(k);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk({tag, "_accepted"}, {63'd0, got}, 64'd1);
    endtask

    task automatic drain(input string tag, input int budget);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || out_valid) && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Output monitor: pops the scoreboard on every step handshake
    initial begin
        exp_t cur;
        exp_t prev_s;
        exp_t e;
        logic prev_stall;
        prev_stall = 1'b0;
        prev_s = '0;
        forever begin
            @(negedge clk);
            cur = '{mask: out_vld_mask, fmt: out_fmt, step: out_step, first: out_first, last: out_last};
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) chk("hold_stable", {out_valid, cur}, {1'b1, prev_s});
                if (req_valid && req_ready) acc_q.push_back(cyc);
                if (out_valid && !out_ready) stall_cnt++;
                if (out_valid && out_ready) begin
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_step", {63'd0, out_valid}, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("step", 64'(cur), 64'(e));
                        if (out_last) last_q.push_back(cyc);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_s = cur;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired: compared=%0d mismatched=%0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        int a0;
        int l0;
        int bound;

        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_mask", 64'(out_vld_mask), 64'd0);
        chk("rst_fmt", 64'(out_fmt), 64'd0);
        chk("rst_step", 64'(out_step), 64'd0);
        chk("rst_first_last", {62'd0, out_first, out_last}, 64'd0);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);

        // FP16 K=24 with a 3-cycle stall on step 1
        h0 = hs_cnt;
        push_req(TCU_FP16_ID, 24);
        do_req("stall", TCU_FP16_ID, 24);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain("stall", 50);
        chk("stall_cycles", 64'(stall_cnt), 64'd3);
        chk("stall_steps", 64'(hs_cnt - h0), 64'd3);
`ifdef TCU_DRL_MASK_SEQ_PERF_EN
        chk("perf_stalls", 64'(perf_stalls), 64'd3);
        chk("perf_steps", 64'(perf_steps), 64'd3);
`endif

        // FP16 K=20 on consecutive cycles
        h0 = hs_cnt;
        push_req(TCU_FP16_ID, 20);
        do_req("fp16_k20", TCU_FP16_ID, 20);
        drain("fp16_k20", 50);
        chk("fp16_k20_steps", 64'(hs_cnt - h0), 64'd3);
        chk("fp16_k20_latency", 64'(last_q[$] - acc_q[$]), 64'd3);

        // FP32 K=5
        h0 = hs_cnt;
        push_req(TCU_FP32_ID, 5);
        do_req("fp32_k5", TCU_FP32_ID, 5);
        drain("fp32_k5", 50);
        chk("fp32_k5_steps", 64'(hs_cnt - h0), 64'd2);

        // Degenerate: BF16 K=0 and unsupported fmt
        h0 = hs_cnt;
        push_req(TCU_BF16_ID, 0);
        do_req("bf16_k0", TCU_BF16_ID, 0);
        drain("bf16_k0", 50);
        chk("bf16_k0_steps", 64'(hs_cnt - h0), 64'd1);
        h0 = hs_cnt;
        push_req(3'b111, 9);
        do_req("badfmt", 3'b111, 9);
        drain("badfmt", 50);
        chk("badfmt_steps", 64'(hs_cnt - h0), 64'd1);

        // Back-to-back K=8 requests with req_valid held high
        a0 = acc_q.size();
        l0 = last_q.size();
        push_req(TCU_FP16_ID, 8);
        push_req(TCU_FP16_ID, 8);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_fmt   = TCU_FP16_ID;
        req_count = 16'd8;
        bound = 0;
        while (acc_q.size() < a0 + 2 && bound < 30) begin
            @(negedge clk);
            bound++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("b2b_accepts", 64'(acc_q.size() - a0), 64'd2);
        drain("b2b", 50);
        if (acc_q.size() >= a0 + 2 && last_q.size() >= l0 + 1)
            chk("b2b_bubble", 64'(acc_q[a0 + 1] - last_q[l0]), 64'd1);
        else
            chk("b2b_events", 64'(last_q.size() - l0), 64'd2);

        // Reset during step 1 of an FP16 K=20 request
        push_req(TCU_FP16_ID, 20);
        do_req("abort", TCU_FP16_ID, 20);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        reset_n   = 1'b0;
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_req_ready", {63'd0, req_ready}, 64'd1);
        h0 = hs_cnt;
        repeat (5) @(negedge clk);
        chk("abort_no_residual", 64'(hs_cnt - h0), 64'd0);
        push_req(TCU_FP16_ID, 4);
        do_req("post_abort", TCU_FP16_ID, 4);
        drain("post_abort", 50);
        chk("post_abort_steps", 64'(hs_cnt - h0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tcu_drl_mask_seq.md
# tcu_drl_mask_seq

Step sequencer directly upstream of the TCU DRL lane-mask stage. It accepts one dot-product request (format plus total valid element count K), splits it into consecutive steps of at most one datapath-width of elements, and emits one `vld_mask` per step with first/last markers. A valid/ready handshake on both sides supports full throughput under backpressure. The downstream lane-mask stage converts each emitted `vld_mask` into per-lane masks.

## Interface
- `MAX_INPUTS`, default `TCU_MAX_INPUTS`: mask width per step; must be even and ≥2.
- `KW`, default 16: width of the element count.
- `SW`, default `KW`: width of the step index.
- `clk`  in  1  clock.
- `reset_n`  in  1  reset; synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_fmt`  in  3  format ID (`TCU_FP32_ID`, `TCU_FP16_ID`, `TCU_BF16_ID`).
- `req_count`  in  KW  total valid elements K.
- `out_valid`  out  1  step present.
- `out_ready`  in  1  downstream accepts step.
- `out_vld_mask`  out  MAX_INPUTS  per-input valid mask for this step.
- `out_fmt`  out  3  latched request format.
- `out_step`  out  SW  step index, 0-based.
- `out_first`  out  1  first step of request.
- `out_last`  out  1  last step of request.

## Operation
- States: IDLE, RUN.
- IDLE:
  - `req_ready`=1.
  - On request handshake: latch `req_fmt`; set `rem`=`req_count`, step=0; go to RUN.
- Elements per step, EPS:
  - FP32: MAX_INPUTS/2.
  - FP16 and BF16: MAX_INPUTS.
- Step mask, with n = min(rem, EPS):
  - FP16/BF16: bits [n-1:0] set.
  - FP32: bits [2n-1:0] set, two mask bits per element.
  - All other bits are 0.
- RUN:
  - `out_valid`=1 and `req_ready`=0.
  - `out_last`=1 when rem ≤ EPS.
  - `out_first`=1 when step=0.
  - On output handshake with `out_last`=0: rem -= EPS, step += 1.
  - On output handshake with `out_last`=1: go to IDLE.
- Degenerate cases: K=0, or an unsupported fmt.
  - Exactly one step is emitted, with mask=0 and first=last=1.
  - The fmt value is forwarded unchanged, so the downstream stage stays in lockstep.
- Number of steps is ceil(K/EPS), minimum 1.
- `rem` is KW bits wide and never underflows, because the last step ends the request.
- `step` wraps modulo 2^SW. It cannot wrap when SW ≥ KW.

## Timing
- Reset (reset_n=0 at a clock edge):
  - State=IDLE.
  - `out_valid`=0, `out_vld_mask`=0, `out_fmt`=0, `out_step`=0, `out_first`=0, `out_last`=0.
  - `req_ready`=1 from the first cycle after reset deasserts.
- All outputs are registered, except `req_ready`, which decodes directly from state.
- Latency:
  - Request accepted at edge T → first step valid in the cycle after T.
  - While `out_ready` is held high, one step per cycle.
- A bubble is mandatory: after the last-step handshake at edge T, `req_ready`=1 only in the cycle after T. There is no same-cycle request chaining.
- While `out_valid`=1 and `out_ready`=0, all `out_*` values hold stable.
- `out_valid` never drops without a handshake, except on reset.
- reset_n low mid-request aborts the request immediately. No partial step follows.
- `req_*` inputs are ignored in RUN.

## Configuration
- `TCU_DRL_MASK_SEQ_PERF_EN` defined:
  - Adds output ports `perf_steps` [31:0], which counts output handshakes.
  - Adds output ports `perf_stalls` [31:0], which counts cycles with `out_valid && !out_ready`.
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Add to the shared `VX_tcu_pkg` (which already holds the fmt IDs):
  - A packed step typedef {vld_mask, fmt, step, first, last}.
  - An EPS helper function keyed by fmt.
- One combinational sub-module, `tcu_drl_mask_therm`:
  - Inputs: n and fmt.
  - Output: the thermometer mask for FP16/BF16, or the doubled thermometer mask for FP32.
- The top level holds the FSM, the rem/step counters and the output register.

## Test plan
All scenarios use MAX_INPUTS=8.
- FP16, K=20, `out_ready`=1 → 3 steps on consecutive cycles.
  - Masks 0xFF, 0xFF, 0x0F; steps 0, 1, 2.
  - first on step 0 only; last on step 2 only.
- FP32, K=5 → masks 0xFF, 0x03; `out_fmt`=`TCU_FP32_ID`; last on step 1.
- BF16, K=0 → one step with mask 0x00 and first=last=1. Unsupported fmt 3'b111 with K=9 gives the same single zero step, with fmt=3'b111.
- FP16, K=24, with `out_ready` low for 3 cycles during step 1:
  - Step 1 outputs hold stable throughout the stall.
  - Total 3 steps.
  - With `TCU_DRL_MASK_SEQ_PERF_EN`: perf_stalls=3 and perf_steps=3.
- Back-to-back requests, K=8 each, with `req_valid` held high:
  - The second request is accepted exactly one cycle after the first last-step handshake.
  - Each request emits mask 0xFF, first=last=1.
- reset_n pulsed low during step 1 of a K=20 request:
  - The next cycle shows `out_valid`=0 and `req_ready`=1.
  - No residual steps follow.
  - A new K=4 FP16 request yields a single step with mask 0x0F.
